// File: rtl/pixel_framer_if.sv
// Video-in / framed-pixel-out signal bundle for pixel_framer.
// slave is the framer's view; master is the source/sink side that drives the video.
interface pixel_framer_if;
  logic        i_vsync;
  logic        i_de;
  logic [23:0] i_pixel;
  logic [31:0] o_data;
  logic        o_valid;
  logic        o_sof;
  logic        o_sol;
  logic [15:0] o_xpos;
  logic [15:0] o_ypos;
  logic [15:0] o_width;
  logic [15:0] o_height;
  logic        o_locked;

  modport slave (
    input  i_vsync, i_de, i_pixel,
    output o_data, o_valid, o_sof, o_sol, o_xpos, o_ypos, o_width, o_height, o_locked
  );

  modport master (
    output i_vsync, i_de, i_pixel,
    input  o_data, o_valid, o_sof, o_sol, o_xpos, o_ypos, o_width, o_height, o_locked
  );
endinterface

// File: rtl/pixel_framer.sv
// Frames a raw vsync/de pixel stream into coordinate-tagged words and measures frame geometry.
// Define PIXEL_FRAMER_LOCK_EN to build geometry lock detection (o_locked); otherwise o_locked is 0.
module pixel_framer (
  input  logic             i_clk,
  input  logic             i_reset,
  pixel_framer_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, WAIT_DE, LINE, HBLANK} state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t      state_q, state_d;
  logic        vsync_q;
  logic        valid_q, valid_d;
  logic        sof_q, sof_d;
  logic        sol_q, sol_d;
  logic [23:0] data_q, data_d;
  logic [15:0] xpos_q, xpos_d;
  logic [15:0] ypos_q, ypos_d;
  logic [15:0] width_q, width_d;
  logic [15:0] height_q, height_d;
  logic [15:0] fw_q, fw_d;
  logic        vs_rise;
  logic [15:0] cur_w;

  assign vs_rise = bus.i_vsync & ~vsync_q;
  assign cur_w   = sat_inc(xpos_q);

  always_comb begin
    state_d  = state_q;
    valid_d  = 1'b0;
    sof_d    = 1'b0;
    sol_d    = 1'b0;
    data_d   = data_q;
    xpos_d   = xpos_q;
    ypos_d   = ypos_q;
    width_d  = width_q;
    height_d = height_q;
    fw_d     = fw_q;
    if (vs_rise) begin
      // vsync wins over a coincident pixel; only frames that produced pixels report geometry
      state_d = WAIT_DE;
      if (state_q == LINE || state_q == HBLANK) begin
        width_d  = (state_q == LINE && ypos_q == 16'd0) ? cur_w : fw_q;
        height_d = sat_inc(ypos_q);
      end
    end else begin
      unique case (state_q)
        IDLE: ;
        WAIT_DE: if (bus.i_de) begin
          state_d = LINE;
          valid_d = 1'b1;
          sof_d   = 1'b1;
          sol_d   = 1'b1;
          data_d  = bus.i_pixel;
          xpos_d  = 16'd0;
          ypos_d  = 16'd0;
        end
        LINE: if (bus.i_de) begin
          valid_d = 1'b1;
          data_d  = bus.i_pixel;
          xpos_d  = sat_inc(xpos_q);
        end else begin
          state_d = HBLANK;
          if (ypos_q == 16'd0) fw_d = cur_w;
        end
        HBLANK: if (bus.i_de) begin
          state_d = LINE;
          valid_d = 1'b1;
          sol_d   = 1'b1;
          data_d  = bus.i_pixel;
          xpos_d  = 16'd0;
          ypos_d  = sat_inc(ypos_q);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      vsync_q  <= 1'b1;
      valid_q  <= 1'b0;
      sof_q    <= 1'b0;
      sol_q    <= 1'b0;
      data_q   <= '0;
      xpos_q   <= '0;
      ypos_q   <= '0;
      width_q  <= '0;
      height_q <= '0;
      fw_q     <= '0;
    end else begin
      state_q  <= state_d;
      vsync_q  <= bus.i_vsync;
      valid_q  <= valid_d;
      sof_q    <= sof_d;
      sol_q    <= sol_d;
      data_q   <= data_d;
      xpos_q   <= xpos_d;
      ypos_q   <= ypos_d;
      width_q  <= width_d;
      height_q <= height_d;
      fw_q     <= fw_d;
    end
  end

`ifdef PIXEL_FRAMER_LOCK_EN
  logic line_ok_q, line_ok_d;
  logic have_prev_q, have_prev_d;
  logic locked_q, locked_d;
  logic frame_end, line_end, mismatch;

  assign frame_end = vs_rise && (state_q == LINE || state_q == HBLANK);
  assign line_end  = !vs_rise && state_q == LINE && !bus.i_de;
  assign mismatch  = (ypos_q != 16'd0) && (cur_w != fw_q);

  always_comb begin
    line_ok_d   = line_ok_q;
    have_prev_d = have_prev_q;
    locked_d    = locked_q;
    if (frame_end) begin
      // a frame cut off mid-line still has its last line checked here
      locked_d    = have_prev_q && line_ok_q && (width_d == width_q) && (height_d == height_q)
                    && !(state_q == LINE && mismatch);
      have_prev_d = 1'b1;
      line_ok_d   = 1'b1;
    end else if (sof_d) begin
      line_ok_d = 1'b1;
    end else if (line_end && mismatch) begin
      line_ok_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      line_ok_q   <= 1'b1;
      have_prev_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      line_ok_q   <= line_ok_d;
      have_prev_q <= have_prev_d;
      locked_q    <= locked_d;
    end
  end

  assign bus.o_locked = locked_q;
`else
  assign bus.o_locked = 1'b0;
`endif

  assign bus.o_data   = {8'h00, data_q};
  assign bus.o_valid  = valid_q;
  assign bus.o_sof    = sof_q;
  assign bus.o_sol    = sol_q;
  assign bus.o_xpos   = xpos_q;
  assign bus.o_ypos   = ypos_q;
  assign bus.o_width  = width_q;
  assign bus.o_height = height_q;

endmodule

// File: tb/tb_pixel_framer.sv
// Directed bench for pixel_framer: framing, geometry, vsync priority, reset and lock behaviour.
module tb_pixel_framer;
  logic clk = 1'b0;
  logic rst;
  int   nchk = 0, nerr = 0;
  int   nval, nsof, nsol;
  logic [31:0] exp_lock;

  pixel_framer_if bus();

  pixel_framer dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [23:0] pix(input int x, input int y);
    if (x == 2 && y == 1) return 24'hABCDEF;
    return {8'(8'h10 + y), 8'(8'h20 + x), 8'h5A};
  endfunction

  // drive one cycle of video, then sample the registered result just after the edge
  task automatic cyc(input logic vs, input logic de, input logic [23:0] p);
    bus.i_vsync = vs;
    bus.i_de    = de;
    bus.i_pixel = p;
    @(posedge clk);
    #1;
    if (bus.o_valid) nval++;
    if (bus.o_sof)   nsof++;
    if (bus.o_sol)   nsol++;
  endtask

  task automatic vs_pulse();
    cyc(1'b1, 1'b0, 24'h0);
    cyc(1'b0, 1'b0, 24'h0);
  endtask

  // h lines of w pixels (line longline gets 5), each followed by 2 blank cycles
  task automatic frame(input int w, input int h, input int longline);
    int lw, tot;
    nval = 0; nsof = 0; nsol = 0; tot = 0;
    for (int y = 0; y < h; y++) begin
      lw = (y == longline) ? 5 : w;
      tot += lw;
      for (int x = 0; x < lw; x++) begin
        cyc(1'b0, 1'b1, pix(x, y));
        chk("px_x", 32'(bus.o_xpos), 32'(x));
        chk("px_y", 32'(bus.o_ypos), 32'(y));
        chk("px_d", bus.o_data, {8'h00, pix(x, y)});
      end
      for (int b = 0; b < 2; b++) begin
        cyc(1'b0, 1'b0, 24'hFFFFFF);
        chk("blank_v", 32'(bus.o_valid), 32'd0);
        chk("hold_d", bus.o_data, {8'h00, pix(lw - 1, y)});
        chk("hold_x", 32'(bus.o_xpos), 32'(lw - 1));
      end
    end
    chk("sof_cnt", 32'(nsof), 32'd1);
    chk("sol_cnt", 32'(nsol), 32'(h));
    chk("val_cnt", 32'(nval), 32'(tot));
  endtask

  initial begin
`ifdef PIXEL_FRAMER_LOCK_EN
    exp_lock = 32'd1;
`else
    exp_lock = 32'd0;
`endif
    bus.i_vsync = 1'b0; bus.i_de = 1'b0; bus.i_pixel = '0;
    rst = 1'b1;
    repeat (3) cyc(1'b0, 1'b1, 24'h123456);
    chk("rst_valid",  32'(bus.o_valid),  32'd0);
    chk("rst_sof",    32'(bus.o_sof),    32'd0);
    chk("rst_sol",    32'(bus.o_sol),    32'd0);
    chk("rst_data",   bus.o_data,        32'd0);
    chk("rst_x",      32'(bus.o_xpos),   32'd0);
    chk("rst_y",      32'(bus.o_ypos),   32'd0);
    chk("rst_w",      32'(bus.o_width),  32'd0);
    chk("rst_h",      32'(bus.o_height), 32'd0);
    chk("rst_lock",   32'(bus.o_locked), 32'd0);
    rst = 1'b0;

    // vsync held low after reset: no edge, pixels ignored in IDLE
    nval = 0;
    repeat (4) cyc(1'b0, 1'b1, 24'h111111);
    chk("idle_noval", 32'(nval), 32'd0);

    // frames 1 and 2: identical 4x3
    vs_pulse();
    frame(4, 3, -1);
    chk("f1_w_pre", 32'(bus.o_width), 32'd0);
    vs_pulse();
    chk("f1_w", 32'(bus.o_width),  32'd4);
    chk("f1_h", 32'(bus.o_height), 32'd3);
    chk("f1_lock", 32'(bus.o_locked), 32'd0);
    frame(4, 3, -1);
    vs_pulse();
    chk("f2_w", 32'(bus.o_width),  32'd4);
    chk("f2_h", 32'(bus.o_height), 32'd3);
    chk("f2_lock", 32'(bus.o_locked), exp_lock);

    // frame 3: line 1 is 5 pixels wide
    frame(4, 3, 1);
    vs_pulse();
    chk("f3_w", 32'(bus.o_width),  32'd4);
    chk("f3_h", 32'(bus.o_height), 32'd3);
    chk("f3_lock", 32'(bus.o_locked), 32'd0);

    // 3x2 frame, then an empty frame must not disturb the geometry
    frame(3, 2, -1);
    vs_pulse();
    chk("f4_w", 32'(bus.o_width),  32'd3);
    chk("f4_h", 32'(bus.o_height), 32'd2);
    vs_pulse();
    chk("empty_w", 32'(bus.o_width),  32'd3);
    chk("empty_h", 32'(bus.o_height), 32'd2);
    chk("empty_lock", 32'(bus.o_locked), 32'd0);

    // vsync edge coincident with de mid line 1
    for (int x = 0; x < 4; x++) cyc(1'b0, 1'b1, pix(x, 0));
    cyc(1'b0, 1'b0, 24'h0);
    cyc(1'b0, 1'b0, 24'h0);
    cyc(1'b0, 1'b1, pix(0, 1));
    cyc(1'b0, 1'b1, pix(1, 1));
    cyc(1'b1, 1'b1, 24'h777777);
    chk("coin_valid", 32'(bus.o_valid), 32'd0);
    chk("coin_hold",  bus.o_data, {8'h00, pix(1, 1)});
    chk("coin_w", 32'(bus.o_width),  32'd4);
    chk("coin_h", 32'(bus.o_height), 32'd2);
    nsof = 0;
    cyc(1'b0, 1'b0, 24'h0);
    cyc(1'b0, 1'b1, 24'h345678);
    chk("coin_nvalid", 32'(bus.o_valid), 32'd1);
    chk("coin_nsof",   32'(bus.o_sof),   32'd1);
    chk("coin_nsol",   32'(bus.o_sol),   32'd1);
    chk("coin_nx",     32'(bus.o_xpos),  32'd0);
    chk("coin_ny",     32'(bus.o_ypos),  32'd0);
    chk("coin_nd",     bus.o_data,       32'h00345678);

    // reset in the middle of line 2 of this frame
    for (int x = 1; x < 4; x++) cyc(1'b0, 1'b1, pix(x, 0));
    cyc(1'b0, 1'b0, 24'h0);
    cyc(1'b0, 1'b1, pix(0, 1));
    rst = 1'b1;
    cyc(1'b0, 1'b1, pix(1, 1));
    cyc(1'b0, 1'b1, pix(2, 1));
    rst = 1'b0;
    chk("mrst_valid", 32'(bus.o_valid), 32'd0);
    chk("mrst_w",     32'(bus.o_width), 32'd0);
    nval = 0;
    for (int x = 0; x < 5; x++) cyc(1'b0, 1'b1, pix(x, 2));
    chk("mrst_noval", 32'(nval), 32'd0);
    nsof = 0; nval = 0;
    vs_pulse();
    chk("mrst_vs_noval", 32'(nval), 32'd0);
    cyc(1'b0, 1'b1, 24'hC0FFEE);
    chk("mrst_valid1", 32'(bus.o_valid), 32'd1);
    chk("mrst_sof1",   32'(bus.o_sof),   32'd1);
    chk("mrst_data1",  bus.o_data,       32'h00C0FFEE);
    chk("mrst_lock",   32'(bus.o_locked), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/pixel_framer.md
PIXEL_FRAMER -- requirements
Module: pixel_framer

Interface
REQ-001 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-002 i_clk  input  1  pixel clock; all logic on its rising edge.
REQ-003 i_reset  input  1  synchronous active-high reset.
REQ-004 i_vsync  input  1  vertical sync, active-high; frame boundary on its rising edge.
REQ-005 i_de  input  1  data enable; high during active pixels.
REQ-006 i_pixel  input  24  RGB pixel, {R,G,B}, valid when i_de high.
REQ-007 o_data  output  32  pixel word {8'h00, pixel} for the downstream sampling stage.
REQ-008 o_valid  output  1  o_data holds an active pixel this cycle.
REQ-009 o_sof  output  1  one-cycle pulse coincident with first valid pixel of a frame.
REQ-010 o_sol  output  1  one-cycle pulse coincident with first valid pixel of each line.
REQ-011 o_xpos, o_ypos  output  16 each  coordinates of the pixel in o_data.
REQ-012 o_width, o_height  output  16 each  dimensions of last completed frame.
REQ-013 o_locked  output  1  frame geometry stable (see Configuration).

Function
REQ-014 State machine SHALL have states IDLE, WAIT_DE, LINE, HBLANK.
REQ-015 IDLE -> WAIT_DE on i_vsync rising edge (i_vsync=1, previous registered i_vsync=0); no pixels emitted in IDLE.
REQ-016 WAIT_DE -> LINE when i_de=1; that pixel emitted with x=0, y=0, o_sof=1, o_sol=1.
REQ-017 LINE -> HBLANK when i_de=0; candidate line width = last x + 1.
REQ-018 HBLANK -> LINE when i_de=1; y increments, x=0, o_sol=1.
REQ-019 In LINE with i_de=1, x increments by one per pixel, saturating at 16'hFFFF; y saturates likewise.
REQ-020 An i_vsync rising edge from any state SHALL force WAIT_DE; if the prior state was LINE or HBLANK, o_width <= first-line width and o_height <= y+1 of the ending frame in the same cycle.
REQ-021 Vsync edge coincident with i_de=1 SHALL take priority: pixel discarded, o_valid=0.
REQ-022 All outputs registered; latency i_pixel/i_de -> o_data/o_valid exactly one clock.
REQ-023 o_data, o_xpos, o_ypos SHALL hold their last value while o_valid=0.
REQ-024 A frame ending with no pixels (vsync-to-vsync with no i_de) SHALL not update o_width/o_height.

Reset
REQ-025 On i_reset: state IDLE, o_valid=0, o_sof=0, o_sol=0, o_data=0, o_xpos=0, o_ypos=0, o_width=0, o_height=0, o_locked=0, registered vsync=1 (no false edge on release).
REQ-026 Reset mid-frame SHALL discard the frame in progress; first output after release follows the next vsync rising edge.

Configuration
REQ-027 Macro PIXEL_FRAMER_LOCK_EN SHALL control lock detection.
REQ-028 Defined: o_locked rises when two consecutive completed frames report identical width and height and every line of the second frame matched the first-line width; it clears at the frame end revealing any mismatch.
REQ-029 Undefined: o_locked SHALL be constant 0 and no lock comparison logic is built.

Verification
REQ-030 Reset, vsync pulse, 3 lines of 4 pixels (de 4 on / 2 off), vsync -> o_sof once, o_sol 3 times, 12 o_valid, o_width=4, o_height=3 after second vsync.
REQ-031 Pixel 24'hABCDEF at x=2,y=1 -> one cycle later o_data=32'h00ABCDEF, o_xpos=2, o_ypos=1.
REQ-032 Assert i_reset mid-line 2, release, drive pixels before next vsync -> o_valid stays 0 until next vsync then first pixel with o_sof=1.
REQ-033 Vsync rising edge in same cycle as i_de=1 -> no o_valid that cycle, state WAIT_DE, next i_de pixel has o_sof=1.
REQ-034 With PIXEL_FRAMER_LOCK_EN: two identical 4x3 frames -> o_locked=1 at end of second; third frame with one 5-pixel line -> o_locked=0 at its end; without macro o_locked=0 throughout.
